// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Binary -> 4-digit BCD via iterative double-dabble, then time-
//            multiplexed onto a 6-bit BCD bus with active-low anode selects.
//            Optional macro: LEADING_ZERO_BLANK_EN (dark leading-zero digits).
// Revision : 1.0  initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    output logic [5:0]       bcd,
    output logic [3:0]       an,
    output logic             busy,
    output logic             ovf
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam int c_ref_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [WIDTH-1:0]   c_max      = WIDTH'(9999);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_ref_w-1:0] c_ref_last = c_ref_w'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_busy;
    logic               w_start;
    logic               w_over;

    logic [WIDTH-1:0]   r_last_val;
    logic [WIDTH-1:0]   r_shreg;
    logic [15:0]        r_bcd_acc;
    logic [15:0]        w_adj;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ovf_n;
    logic [15:0]        r_digit;
    logic               r_ovf;
    logic [3:0]         r_blank;
    logic [3:0]         w_blank;

    logic [c_ref_w-1:0] r_refresh;
    logic [1:0]         r_sel;
    logic [1:0]         w_sel_next;
    logic               w_wrap;
    logic [3:0]         w_digit_sel;
    logic [3:0]         r_an;
    logic [5:0]         r_bcd;

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_start = (r_state == S_IDLE) && (value != r_last_val);
    assign w_over  = (32'(value) > 32'd9999);

    // Add-3 correction applied to every nibble before each shift.
    for (genvar k = 0; k < 4; k++) begin : g_add3
        assign w_adj[4*k +: 4] = (r_bcd_acc[4*k +: 4] >= 4'd5)
                               ? r_bcd_acc[4*k +: 4] + 4'd3
                               : r_bcd_acc[4*k +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more-significant digit are zero.
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (r_bcd_acc[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_bcd_acc[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_bcd_acc[7:4]  == 4'd0);
    end
`else
    assign w_blank = 4'b0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_val <= '0;
            r_shreg    <= '0;
            r_bcd_acc  <= '0;
            r_cnt      <= '0;
            r_ovf_n    <= 1'b0;
            r_digit    <= '0;
            r_ovf      <= 1'b0;
            r_blank    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_last_val <= value;
                        r_shreg    <= w_over ? c_max : value;
                        r_ovf_n    <= w_over;
                        r_bcd_acc  <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bcd_acc <= {w_adj[14:0], r_shreg[WIDTH-1]};
                    r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt + 1'b1;
                end
                S_LOAD: begin
                    r_digit <= r_bcd_acc;
                    r_ovf   <= r_ovf_n;
                    r_blank <= w_blank;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan: free-running, only observes the committed digit regs
    // ------------------------------------------------------------------
    assign w_wrap     = (r_refresh == c_ref_last);
    assign w_sel_next = r_sel + 2'd1;

    always_comb begin
        w_digit_sel = r_digit[3:0];
        case (w_sel_next)
            2'd0:    w_digit_sel = r_digit[3:0];
            2'd1:    w_digit_sel = r_digit[7:4];
            2'd2:    w_digit_sel = r_digit[11:8];
            default: w_digit_sel = r_digit[15:12];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_sel     <= 2'd0;
            r_an      <= 4'b1110;
            r_bcd     <= 6'h00;
        end else if (w_wrap) begin
            r_refresh <= '0;
            r_sel     <= w_sel_next;
            r_an      <= r_blank[w_sel_next] ? 4'b1111 : ~(4'b0001 << w_sel_next);
            r_bcd     <= {2'b00, w_digit_sel};
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    assign an   = r_an;
    assign bcd  = r_bcd;
    assign busy = w_busy;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Randomised self-checking bench; decimal-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int WIDTH = 14;
    localparam int DIV   = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] value;
    logic [5:0]       bcd;
    logic [3:0]       an;
    logic             busy;
    logic             ovf;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state (transaction-level: pending conversion + timer)
    int m_last, m_conv, m_left, m_ovf, m_ref, m_sel, e_an, e_bcd;
    int m_dig[4];
    bit m_blank[4];

    display_scan_ctrl #(.WIDTH(WIDTH), .REFRESH_DIV(DIV)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .bcd   (bcd),
        .an    (an),
        .busy  (busy),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_last = 0; m_conv = 0; m_left = 0; m_ovf = 0;
        m_ref  = 0; m_sel  = 0; e_an   = 4'b1110; e_bcd = 0;
        for (int k = 0; k < 4; k++) begin
            m_dig[k]   = 0;
            m_blank[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int v, nd;
        if (m_ref == DIV - 1) begin
            m_ref = 0;
            m_sel = (m_sel + 1) % 4;
            e_an  = m_blank[m_sel] ? 15 : (15 ^ (1 << m_sel));
            e_bcd = m_dig[m_sel];
        end else begin
            m_ref++;
        end
        if (m_left == 0) begin
            if (int'(value) != m_last) begin
                m_last = int'(value);
                m_conv = int'(value);
                m_left = WIDTH + 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                v        = (m_conv > 9999) ? 9999 : m_conv;
                m_ovf    = (m_conv > 9999) ? 1 : 0;
                m_dig[0] = v % 10;
                m_dig[1] = (v / 10) % 10;
                m_dig[2] = (v / 100) % 10;
                m_dig[3] = v / 1000;
                nd = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
                for (int k = 0; k < 4; k++) m_blank[k] = LZB && (k >= nd);
            end
        end
    endtask

    task automatic check_outputs();
        chk("an",   int'(an),   e_an);
        chk("bcd",  int'(bcd),  e_bcd);
        chk("busy", int'(busy), (m_left != 0) ? 1 : 0);
        chk("ovf",  int'(ovf),  m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        run(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        int hold;
        rst_n = 1'b1;
        value = '0;
        model_reset();

        // Reset and free-running scan of "0000"
        async_reset(3);
        run(24);

        // 1234 from IDLE: busy window length and digit scan
        value    = WIDTH'(1234);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("busy_len", busy_cnt, WIDTH + 1);
        run(20);

        // Overflow saturates, next in-range value clears ovf
        value = WIDTH'(12000);
        run(40);
        value = WIDTH'(7);
        run(40);

        // Change while busy: first value loads, second converts after
        value = WIDTH'(5678);
        run(3);
        value = WIDTH'(9);
        run(60);

        // Reset mid-SHIFT with value held: reconverts after release
        value = WIDTH'(1234);
        run(5);
        async_reset(2);
        run(40);

        // Random values, hold times and occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) value = WIDTH'($urandom_range(10000, 16383));
            else                           value = WIDTH'($urandom_range(0, 9999));
            hold = $urandom_range(1, 40);
            run(hold);
            if ($urandom_range(0, 24) == 0) async_reset($urandom_range(1, 3));
        end
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
